// File: rtl/mempool_l2_banked_pkg.sv
// Shared parameters and helpers for the banked L2 path between axi2mem and the
// word-interleaved SRAM banks.
// No ports (package).
package mempool_l2_banked_pkg;

    localparam int unsigned L2DataWidth      = 512;
    localparam int unsigned L2AddrWidth      = 32;
    localparam int unsigned L2NumBanks       = 4;
    localparam int unsigned L2WordsPerBank   = 1024;
    localparam int unsigned L2SramLatency    = 1;
    localparam int unsigned L2MaxOutstanding = 4;
    localparam logic [31:0] L2BaseAddr       = 32'h8000_0000;

    // Index width that stays legal (>= 1 bit) for single-entry structures.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mempool_l2_banked_if.sv
// L2 request/response channel. Signal names carry the direction as seen by the
// L2 (slave) side.
//   req_*: valid/ready request with byte address, write enable, data, strobes.
//   rsp_*: valid/ready response with read data and out-of-range error flag.
interface mempool_l2_banked_if
    import mempool_l2_banked_pkg::*;
#(
    parameter int unsigned DataWidth = L2DataWidth,
    parameter int unsigned AddrWidth = L2AddrWidth
);

    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [AddrWidth-1:0]   req_addr_i;
    logic                   req_we_i;
    logic [DataWidth-1:0]   req_wdata_i;
    logic [DataWidth/8-1:0] req_strb_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [DataWidth-1:0]   rsp_rdata_o;
    logic                   rsp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_wdata_i, req_strb_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/mempool_l2_banked_rsp_fifo.sv
// Synchronous-reset response FIFO with parametrised depth and payload type.
//   push_i/data_i: enqueue; pop_i: dequeue the head; valid_o/data_o: head entry.
// Push while full is legal only together with a pop.
module mempool_l2_banked_rsp_fifo
    import mempool_l2_banked_pkg::*;
#(
    parameter int unsigned Depth = L2MaxOutstanding,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output logic valid_o,
    output T     data_o
);

    localparam int unsigned PtrW = clog2_min1(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [CntW-1:0] cnt_d, cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Pointer and occupancy update; simultaneous push and pop keep occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_i && !pop_i)      cnt_d = cnt_q + CntW'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar g = 0; g < Depth; g++) begin : gen_slot
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                mem_q[g] <= '0;
            end else if (push_i && (wr_ptr_q == PtrW'(g))) begin
                mem_q[g] <= data_i;
            end
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/tc_sram.sv
// Single-port SRAM bank model with byte enables and configurable read latency.
//   clk_i: clock; req_i/we_i/addr_i/wdata_i/be_i: access; rdata_o: read data
//   valid Latency cycles after a read request. Contents are never reset.
module tc_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                   clk_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] be_i,
    output logic [DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rdata_q [Latency];
    logic [DataWidth-1:0] bit_mask;

    // Expand byte enables into a bit mask for a read-modify-write of the row.
    always_comb begin
        bit_mask = '0;
        for (int unsigned i = 0; i < DataWidth / 8; i++) begin
            bit_mask[i*8 +: 8] = {8{be_i[i]}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            mem_q[addr_i] <= (mem_q[addr_i] & ~bit_mask) | (wdata_i & bit_mask);
        end
    end

    for (genvar s = 0; s < Latency; s++) begin : gen_rd_stage
        if (s == 0) begin : gen_first
            always_ff @(posedge clk_i) begin
                if (req_i && !we_i) begin
                    rdata_q[0] <= mem_q[addr_i];
                end
            end
        end else begin : gen_next
            always_ff @(posedge clk_i) begin
                rdata_q[s] <= rdata_q[s-1];
            end
        end
    end

    assign rdata_o = rdata_q[Latency-1];

endmodule

// File: rtl/mempool_l2_banked.sv
// Banked L2 memory: decodes axi2mem requests onto NumBanks word-interleaved
// SRAM banks, tracks them through a latency-matched pipeline and returns
// in-order responses through a FIFO. Out-of-range addresses get an error
// response without touching any bank.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   l2            : request/response channel (slave side)
//   busy_o        : at least one accepted request not yet responded
module mempool_l2_banked
    import mempool_l2_banked_pkg::*;
#(
    parameter int unsigned          DataWidth      = L2DataWidth,
    parameter int unsigned          AddrWidth      = L2AddrWidth,
    parameter int unsigned          NumBanks       = L2NumBanks,
    parameter int unsigned          WordsPerBank   = L2WordsPerBank,
    parameter int unsigned          SramLatency    = L2SramLatency,
    parameter int unsigned          MaxOutstanding = L2MaxOutstanding,
    parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(L2BaseAddr)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mempool_l2_banked_if.slave l2,
    output logic               busy_o
);

    localparam int unsigned ByteWidth   = DataWidth / 8;
    localparam int unsigned WordOff     = $clog2(ByteWidth);
    localparam int unsigned BankSelBits = $clog2(NumBanks);
    localparam int unsigned BankW       = clog2_min1(NumBanks);
    localparam int unsigned RowW        = clog2_min1(WordsPerBank);
    localparam int unsigned RowLsb      = WordOff + BankSelBits;
    localparam int unsigned CntW        = $clog2(MaxOutstanding + 1);
    localparam int unsigned AddrExtW    = AddrWidth + 1;
    localparam logic [AddrExtW-1:0] L2Span = AddrExtW'(NumBanks * WordsPerBank * ByteWidth);

    typedef struct packed {
        logic                 err;
        logic [DataWidth-1:0] rdata;
    } l2_rsp_t;

    typedef struct packed {
        logic             valid;
        logic             err;
        logic             we;
        logic [BankW-1:0] bank;
    } l2_pipe_t;

    logic [AddrWidth-1:0] offset_c;
    logic                 in_range_c;
    logic                 accept_c;
    logic                 rsp_hs_c;
    logic [BankW-1:0]     bank_c;
    logic [RowW-1:0]      row_c;
    logic [NumBanks-1:0]  bank_req;
    logic [DataWidth-1:0] bank_rdata [NumBanks];
    l2_pipe_t             pipe_d;
    l2_pipe_t             pipe_q [SramLatency];
    l2_pipe_t             pipe_exit;
    l2_rsp_t              rsp_push;
    l2_rsp_t              rsp_head;
    logic                 rsp_valid;
    logic [CntW-1:0]      cnt_d, cnt_q;

    // Address decode; range compare is one bit wider so BaseAddr+span cannot wrap.
    always_comb begin
        offset_c   = l2.req_addr_i - BaseAddr;
        in_range_c = ({1'b0, l2.req_addr_i} >= {1'b0, BaseAddr}) &&
                     ({1'b0, l2.req_addr_i} <  ({1'b0, BaseAddr} + L2Span));
        bank_c     = (NumBanks > 1) ? BankW'(offset_c >> WordOff) : '0;
        row_c      = RowW'(offset_c >> RowLsb);
    end

    assign l2.req_ready_o = (cnt_q < CntW'(MaxOutstanding)) && rst_ni;
    assign accept_c       = l2.req_valid_i && l2.req_ready_o;
    assign rsp_hs_c       = rsp_valid && l2.rsp_ready_i;

    // Only the addressed bank sees a request, and only for in-range accepts.
    always_comb begin
        bank_req = '0;
        if (accept_c && in_range_c) bank_req[bank_c] = 1'b1;
    end

    for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
        tc_sram #(
            .NumWords  (WordsPerBank),
            .DataWidth (DataWidth),
            .Latency   (SramLatency)
        ) i_sram (
            .clk_i   (clk_i),
            .req_i   (bank_req[b]),
            .we_i    (l2.req_we_i),
            .addr_i  (row_c),
            .wdata_i (l2.req_wdata_i),
            .be_i    (l2.req_strb_i),
            .rdata_o (bank_rdata[b])
        );
    end

    // Request tag travelling alongside the SRAM access, SramLatency deep.
    always_comb begin
        pipe_d = l2_pipe_t'{valid: accept_c, err: !in_range_c, we: l2.req_we_i, bank: bank_c};
    end

    for (genvar s = 0; s < SramLatency; s++) begin : gen_pipe
        if (s == 0) begin : gen_first
            always_ff @(posedge clk_i) begin
                if (!rst_ni) pipe_q[0] <= '0;
                else         pipe_q[0] <= pipe_d;
            end
        end else begin : gen_next
            always_ff @(posedge clk_i) begin
                if (!rst_ni) pipe_q[s] <= '0;
                else         pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign pipe_exit = pipe_q[SramLatency-1];

    // Writes and errors return zero data; reads take the tagged bank's output.
    always_comb begin
        rsp_push.err   = pipe_exit.err;
        rsp_push.rdata = (pipe_exit.we || pipe_exit.err) ? '0 : bank_rdata[pipe_exit.bank];
    end

    mempool_l2_banked_rsp_fifo #(
        .Depth (MaxOutstanding),
        .T     (l2_rsp_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pipe_exit.valid),
        .data_i  (rsp_push),
        .pop_i   (rsp_hs_c),
        .valid_o (rsp_valid),
        .data_o  (rsp_head)
    );

    assign l2.rsp_valid_o = rsp_valid;
    assign l2.rsp_rdata_o = rsp_head.rdata;
    assign l2.rsp_err_o   = rsp_head.err;

    // Outstanding credits: bounded by MaxOutstanding so the FIFO never overflows.
    always_comb begin
        cnt_d = cnt_q;
        if (accept_c && !rsp_hs_c)      cnt_d = cnt_q + CntW'(1);
        else if (!accept_c && rsp_hs_c) cnt_d = cnt_q - CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: tb/tb_mempool_l2_banked.sv
// Directed self-checking bench for mempool_l2_banked.
module tb_mempool_l2_banked;
    import mempool_l2_banked_pkg::*;

    localparam int unsigned DW   = 512;
    localparam int unsigned AW   = 32;
    localparam int unsigned NB   = 4;
    localparam int unsigned WPB  = 1024;
    localparam int unsigned LAT  = 2;
    localparam int unsigned MO   = 4;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
        logic [31:0]   cyc;
    } rec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [31:0] cyc   = '0;
    int          tests = 0;
    int          fails = 0;
    int          stalls = 0;
    int          bank_reqs = 0;
    rec_t        exp_q [$];
    rec_t        got_q [$];

    mempool_l2_banked_if #(.DataWidth(DW), .AddrWidth(AW)) l2 ();

    mempool_l2_banked #(
        .DataWidth      (DW),
        .AddrWidth      (AW),
        .NumBanks       (NB),
        .WordsPerBank   (WPB),
        .SramLatency    (LAT),
        .MaxOutstanding (MO),
        .BaseAddr       (BASE)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .l2     (l2),
        .busy_o (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Response and bank-activity monitor.
    always @(negedge clk) begin
        if (rst_n && l2.rsp_valid_o && l2.rsp_ready_i)
            got_q.push_back(rec_t'{err: l2.rsp_err_o, data: l2.rsp_rdata_o, cyc: cyc});
        if (rst_n && (dut.bank_req != '0))
            bank_reqs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int k);
        return {64{8'hA5}} ^ DW'(k);
    endfunction

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [31:0] addr, input logic we, input logic [DW-1:0] wd,
                        input logic [DW/8-1:0] strb, input logic exp_err, input logic [DW-1:0] exp_d);
        int waits = 0;
        l2.req_valid_i = 1'b1;
        l2.req_addr_i  = addr;
        l2.req_we_i    = we;
        l2.req_wdata_i = wd;
        l2.req_strb_i  = strb;
        @(negedge clk);
        while (!l2.req_ready_o && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!l2.req_ready_o) begin
            chk("accept_timeout", DW'(l2.req_ready_o), DW'(1));
        end else begin
            stalls += waits;
            exp_q.push_back(rec_t'{err: exp_err, data: exp_d, cyc: cyc});
        end
        @(posedge clk);
        #1;
        l2.req_valid_i = 1'b0;
    endtask

    // Wait for n responses and compare them in order against the expectations.
    task automatic drain(input int n, input logic check_lat);
        int   t = 0;
        rec_t g;
        rec_t e;
        while (got_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_count", DW'(got_q.size()), DW'(n));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("rsp_err", DW'(g.err), DW'(e.err));
            chk("rsp_data", g.data, e.data);
            if (check_lat) chk("rsp_latency", DW'(g.cyc - e.cyc), DW'(LAT + 1));
        end
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        chk("idle_busy", DW'(busy), DW'(0));
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] part;
    int            b0;

    initial begin
        part = {{63{8'hFF}}, 8'h00};
        l2.req_valid_i = 1'b0;
        l2.req_addr_i  = '0;
        l2.req_we_i    = 1'b0;
        l2.req_wdata_i = '0;
        l2.req_strb_i  = '0;
        l2.rsp_ready_i = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", DW'(l2.req_ready_o), DW'(0));
        chk("rst_rsp_valid", DW'(l2.rsp_valid_o), DW'(0));
        chk("rst_rsp_err",   DW'(l2.rsp_err_o),   DW'(0));
        chk("rst_rsp_rdata", l2.rsp_rdata_o,      DW'(0));
        chk("rst_busy",      DW'(busy),           DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        l2.rsp_ready_i = 1'b1;

        // Write/read-back across banks 1,2,3,0
        for (int i = 0; i < 4; i++) send(BASE + 32'((i + 1) * 64), 1'b1, pat(i), '1, 1'b0, '0);
        for (int i = 0; i < 4; i++) send(BASE + 32'((i + 1) * 64), 1'b0, '0, '0, 1'b0, pat(i));
        drain(8, 1'b1);

        // Partial strobe
        send(BASE + 32'h200, 1'b1, '1, '1, 1'b0, '0);
        send(BASE + 32'h200, 1'b1, '0, 64'h1, 1'b0, '0);
        send(BASE + 32'h200, 1'b0, '0, '0, 1'b0, part);
        drain(3, 1'b1);

        // Backpressure: credits run out at MaxOutstanding
        l2.rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(BASE + 32'((i + 1) * 64), 1'b0, '0, '0, 1'b0, pat(i));
        l2.req_valid_i = 1'b1;
        l2.req_addr_i  = BASE + 32'h200;
        l2.req_we_i    = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("bp_req_ready", DW'(l2.req_ready_o), DW'(0));
            chk("bp_busy",      DW'(busy),           DW'(1));
            chk("bp_rsp_valid", DW'(l2.rsp_valid_o), DW'(1));
            chk("bp_rsp_hold",  l2.rsp_rdata_o,      pat(0));
        end
        @(posedge clk);
        #1;
        l2.rsp_ready_i = 1'b1;
        send(BASE + 32'h200, 1'b0, '0, '0, 1'b0, part);
        send(BASE + 32'h40, 1'b0, '0, '0, 1'b0, pat(0));
        drain(6, 1'b0);

        // Range errors below and just above the window, then the last valid word
        b0 = bank_reqs;
        send(BASE - 32'd64, 1'b0, '0, '0, 1'b1, '0);
        send(BASE + 32'h0004_0000, 1'b0, '0, '0, 1'b1, '0);
        drain(2, 1'b1);
        chk("err_no_bank_req", DW'(bank_reqs), DW'(b0));
        send(BASE + 32'h0003_FFC0, 1'b1, pat(9), '1, 1'b0, '0);
        send(BASE + 32'h0003_FFC0, 1'b0, '0, '0, 1'b0, pat(9));
        drain(2, 1'b1);

        // Streaming: 100 writes then 100 reads back to back
        stalls = 0;
        for (int i = 0; i < 100; i++) send(BASE + 32'(i * 64), 1'b1, pat(100 + i), '1, 1'b0, '0);
        for (int i = 0; i < 100; i++) send(BASE + 32'(i * 64), 1'b0, '0, '0, 1'b0, pat(100 + i));
        chk("stream_stalls", DW'(stalls), DW'(0));
        drain(200, 1'b1);

        // Reset with three requests in flight
        l2.rsp_ready_i = 1'b0;
        send(BASE + 32'h80, 1'b1, pat(77), '1, 1'b0, '0);
        send(BASE + 32'h40, 1'b0, '0, '0, 1'b0, pat(101));
        send(BASE + 32'hC0, 1'b0, '0, '0, 1'b0, pat(103));
        chk("pre_rst_busy", DW'(busy), DW'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", DW'(l2.req_ready_o), DW'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy",      DW'(busy),           DW'(0));
        chk("post_rst_rsp_valid", DW'(l2.rsp_valid_o), DW'(0));
        exp_q.delete();
        got_q.delete();
        l2.rsp_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_rsp", DW'(got_q.size()), DW'(0));
        @(posedge clk);
        #1;
        send(BASE + 32'h80, 1'b0, '0, '0, 1'b0, pat(77));
        send(BASE + 32'h40, 1'b0, '0, '0, 1'b0, pat(101));
        drain(2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
